// File: rtl/sync_sdp_ram.sv
// Simple-dual-port synchronous SRAM built from per-byte storage lanes.
// Self-clears after reset, selectable collision mode, optional output register.

module sync_sdp_ram_lane #(
   parameter int AW      = 8,
   parameter int DPTH    = 256,
   parameter int RD_MODE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wen,
   input  logic [AW-1:0] widx,
   input  logic [7:0]    wdata,
   input  logic          ren,
   input  logic          rhit,
   input  logic          byp,
   input  logic [AW-1:0] ridx,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DPTH];

   always_ff @(posedge clk) begin
      if (wen) mem[widx] <= wdata;
   end

   // Nonblocking write above gives read-first naturally; byp forwards the new byte.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (ren) begin
         if (!rhit)
            rdata <= '0;
         else if (RD_MODE != 0 && byp)
            rdata <= wdata;
         else
            rdata <= mem[ridx];
      end
   end

endmodule

module sync_sdp_ram #(
   parameter int ADR     = 8,
   parameter int DAT     = 8,
   parameter int DPTH    = 256,
   parameter int RD_MODE = 0,
   parameter int OUT_REG = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             we,
   input  logic [ADR-1:0]   waddr,
   input  logic [DAT-1:0]   data_in,
   input  logic [DAT/8-1:0] be,
   input  logic             rd,
   input  logic [ADR-1:0]   raddr,
   output logic [DAT-1:0]   data_out,
   output logic             rd_valid,
   output logic             ready
);

   localparam int NUM_LANES = DAT / 8;
   localparam int AW        = (DPTH > 1) ? $clog2(DPTH) : 1;
   localparam int STAGES    = (OUT_REG != 0) ? 1 : 0;
   localparam logic [ADR:0]  LIM  = (ADR+1)'(DPTH);
   localparam logic [AW-1:0] LAST = AW'(DPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                          state;
   logic [AW-1:0]                   cnt;
   logic                            w_hit, r_hit, wr_acc, rd_acc, clr, coll;
   logic [AW-1:0]                   widx;
   logic [NUM_LANES-1:0][7:0]       wdat;
   logic [NUM_LANES-1:0][7:0]       lane_q;
   logic [NUM_LANES-1:0]            lane_wen, lane_byp;
   logic [STAGES:0]                 vld_pipe;

   assign w_hit  = {1'b0, waddr} < LIM;
   assign r_hit  = {1'b0, raddr} < LIM;
   // Writes are gated by rst so a write on the reset edge cannot race the clear.
   assign wr_acc = ready & cs & we & w_hit & ~rst;
   assign rd_acc = ready & cs & rd;
   assign clr    = (state == CLEAR) & ~rst;
   assign coll   = wr_acc & (waddr == raddr);

   assign widx     = clr ? cnt : waddr[AW-1:0];
   assign wdat     = clr ? '0 : data_in;
   assign lane_wen = clr ? '1 : ({NUM_LANES{wr_acc}} & be);
   assign lane_byp = {NUM_LANES{coll}} & be;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (cnt == LAST) begin
                  state <= RUN;
                  ready <= 1'b1;
               end else
                  cnt <= cnt + 1'b1;
            end
            RUN: state <= RUN;
            default: state <= CLEAR;
         endcase
      end
   end

   sync_sdp_ram_lane #(.AW(AW), .DPTH(DPTH), .RD_MODE(RD_MODE)) u_lane [NUM_LANES-1:0] (
      .clk   (clk),
      .rst   (rst),
      .wen   (lane_wen),
      .widx  (widx),
      .wdata (wdat),
      .ren   (rd_acc),
      .rhit  (r_hit),
      .byp   (lane_byp),
      .ridx  (raddr[AW-1:0]),
      .rdata (lane_q)
   );

   // vld_pipe[0] marks lane_q as fresh; vld_pipe[STAGES] is the outgoing pulse.
   always_ff @(posedge clk) begin
      if (rst)
         vld_pipe <= '0;
      else begin
         vld_pipe[0] <= rd_acc;
         for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   assign rd_valid = vld_pipe[STAGES];

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DAT-1:0] data_q;
         always_ff @(posedge clk) begin
            if (rst)
               data_q <= '0;
            else if (vld_pipe[0])
               data_q <= lane_q;
         end
         assign data_out = data_q;
      end else begin : g_noreg
         assign data_out = lane_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_sdp_ram.sv
// Two instances (read-first/latency 1, write-first/latency 2) driven in lockstep
// and compared every cycle against a word-level reference model.

module tb_sync_sdp_ram;

   localparam int D = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1, cs = 1'b0, we = 1'b0, rd = 1'b0;
   logic [3:0]  waddr = '0, raddr = '0, be = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out0, data_out1;
   logic        rd_valid0, rd_valid1, ready0, ready1;

   int vectors = 0, miscompares = 0;

   logic [31:0] m_mem [D];
   int          clr_left;
   logic        m_ready;
   logic [31:0] e_d0, e_d1, p_d;
   logic        e_v0, e_v1, p_v;

   always #5 clk = ~clk;

   sync_sdp_ram #(.ADR(4), .DAT(32), .DPTH(D), .RD_MODE(0), .OUT_REG(0)) dut0 (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .waddr(waddr), .data_in(data_in), .be(be),
      .rd(rd), .raddr(raddr), .data_out(data_out0), .rd_valid(rd_valid0), .ready(ready0));

   sync_sdp_ram #(.ADR(4), .DAT(32), .DPTH(D), .RD_MODE(1), .OUT_REG(1)) dut1 (
      .clk(clk), .rst(rst), .cs(cs), .we(we), .waddr(waddr), .data_in(data_in), .be(be),
      .rd(rd), .raddr(raddr), .data_out(data_out1), .rd_valid(rd_valid1), .ready(ready1));

   // One clock: drive on negedge, advance the model on posedge, return 1 time unit later.
   task automatic step(input logic r, input logic c, input logic w, input logic [3:0] wa,
                       input logic [31:0] d, input logic [3:0] b, input logic rr,
                       input logic [3:0] ra);
      logic        racc, wacc;
      logic [31:0] old, nw, v1;
      @(negedge clk);
      rst = r; cs = c; we = w; waddr = wa; data_in = d; be = b; rd = rr; raddr = ra;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < D; i++) m_mem[i] = '0;
         clr_left = D; m_ready = 1'b0;
         e_d0 = '0; e_v0 = 1'b0; e_d1 = '0; e_v1 = 1'b0; p_d = '0; p_v = 1'b0;
      end else begin
         racc = m_ready && c && rr;
         wacc = m_ready && c && w && (int'(wa) < D);
         old  = (int'(ra) < D) ? m_mem[int'(ra)] : 32'h0;
         nw   = wacc ? m_mem[int'(wa)] : 32'h0;
         for (int i = 0; i < 4; i++) if (b[i]) nw[i*8 +: 8] = d[i*8 +: 8];
         v1 = (wacc && wa == ra) ? nw : old;
         if (wacc) m_mem[int'(wa)] = nw;
         e_v0 = racc;
         if (racc) e_d0 = old;
         e_v1 = p_v;
         if (p_v) e_d1 = p_d;
         p_v = racc;
         if (racc) p_d = v1;
         if (!m_ready) begin
            clr_left--;
            if (clr_left == 0) m_ready = 1'b1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      int lo = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (data_out0 !== 32'h0 || rd_valid0 !== 1'b0 || ready0 !== 1'b0 ||
          data_out1 !== 32'h0 || rd_valid1 !== 1'b0 || ready1 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_vals got %h %b %b / %h %b %b want 0 0 0", data_out0, rd_valid0,
                  ready0, data_out1, rd_valid1, ready1);
      end
      if (ready0 === 1'b0) lo++;
      for (int i = 0; i < D; i++) begin
         step(0, 1, 1, 4'(i), 32'hFFFF_FFFF, 4'hF, 1, 4'(i));
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || ready0 !== m_ready ||
             data_out1 !== e_d1 || rd_valid1 !== e_v1 || ready1 !== m_ready) begin
            miscompares++;
            $display("FAIL clear_sweep cyc %0d got %h %b %b / %h %b %b want %h %b %b / %h %b", i,
                     data_out0, rd_valid0, ready0, data_out1, rd_valid1, ready1,
                     e_d0, e_v0, m_ready, e_d1, e_v1);
         end
         if (ready0 === 1'b0) lo++;
      end
      vectors++;
      if (lo != D || ready0 !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_rise low_cycles=%0d ready=%b want %0d 1", lo, ready0, D);
      end
      for (int i = 0; i < D + 2; i++) begin
         step(0, 1, 0, 0, 0, 0, logic'(i < D), 4'(i));
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || data_out1 !== e_d1 || rd_valid1 !== e_v1) begin
            miscompares++;
            $display("FAIL clear_readback cyc %0d got %h %b / %h %b want %h %b / %h %b", i,
                     data_out0, rd_valid0, data_out1, rd_valid1, e_d0, e_v0, e_d1, e_v1);
         end
      end
   endtask

   task automatic test_byte_en();
      step(0, 1, 1, 3, 32'hAABB_CCDD, 4'b1111, 0, 0);
      step(0, 1, 1, 3, 32'h1122_3344, 4'b0101, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 3);
      vectors++;
      if (data_out0 !== 32'hAA22_CC44 || rd_valid0 !== 1'b1) begin
         miscompares++;
         $display("FAIL byte_en got %h %b want aa22cc44 1", data_out0, rd_valid0);
      end
      step(0, 1, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (data_out1 !== 32'hAA22_CC44 || rd_valid1 !== 1'b1 || rd_valid0 !== 1'b0) begin
         miscompares++;
         $display("FAIL byte_en_lat2 got %h %b (dut0 vld %b) want aa22cc44 1 (0)",
                  data_out1, rd_valid1, rd_valid0);
      end
   endtask

   task automatic test_collision();
      step(0, 1, 1, 5, 32'h10, 4'hF, 0, 0);
      step(0, 1, 1, 5, 32'h99, 4'hF, 1, 5);
      vectors++;
      if (data_out0 !== 32'h10 || rd_valid0 !== 1'b1) begin
         miscompares++;
         $display("FAIL coll_read_first got %h %b want 00000010 1", data_out0, rd_valid0);
      end
      step(0, 1, 1, 6, 32'hA5A5_A5A5, 4'b0110, 1, 6);
      vectors++;
      if (data_out1 !== 32'h99 || rd_valid1 !== 1'b1) begin
         miscompares++;
         $display("FAIL coll_write_first got %h %b want 00000099 1", data_out1, rd_valid1);
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0);
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || data_out1 !== e_d1 || rd_valid1 !== e_v1) begin
            miscompares++;
            $display("FAIL coll_partial cyc %0d got %h %b / %h %b want %h %b / %h %b", i,
                     data_out0, rd_valid0, data_out1, rd_valid1, e_d0, e_v0, e_d1, e_v1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int nv0 = 0, nv1 = 0;
      for (int i = 0; i < 3; i++) step(0, 1, 1, 4'(i), 32'hC0DE_0000 + 32'(i), 4'hF, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 0, 0, 0, logic'(i < 3), 4'(i));
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || data_out1 !== e_d1 || rd_valid1 !== e_v1) begin
            miscompares++;
            $display("FAIL b2b cyc %0d got %h %b / %h %b want %h %b / %h %b", i,
                     data_out0, rd_valid0, data_out1, rd_valid1, e_d0, e_v0, e_d1, e_v1);
         end
         if (rd_valid0 === 1'b1) nv0++;
         if (rd_valid1 === 1'b1) nv1++;
      end
      vectors++;
      if (nv0 != 3 || nv1 != 3) begin
         miscompares++;
         $display("FAIL b2b_count got %0d/%0d want 3/3", nv0, nv1);
      end
   endtask

   task automatic test_range_gating();
      logic [31:0] hold0;
      step(0, 1, 1, 13, 32'h55, 4'hF, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 13);
      vectors++;
      if (data_out0 !== 32'h0 || rd_valid0 !== 1'b1) begin
         miscompares++;
         $display("FAIL oor_read got %h %b want 0 1", data_out0, rd_valid0);
      end
      step(0, 1, 0, 0, 0, 0, 1, 1);
      hold0 = e_d0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 4'(i), 32'hBAD0_0000, 4'hF, 1, 4'(i));
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || data_out1 !== e_d1 || rd_valid1 !== e_v1) begin
            miscompares++;
            $display("FAIL cs_gate cyc %0d got %h %b / %h %b want %h %b / %h %b", i,
                     data_out0, rd_valid0, data_out1, rd_valid1, e_d0, e_v0, e_d1, e_v1);
         end
      end
      vectors++;
      if (rd_valid0 !== 1'b0 || data_out0 !== hold0) begin
         miscompares++;
         $display("FAIL cs_hold got %h %b want %h 0", data_out0, rd_valid0, hold0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(0, logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom, 4'($urandom), logic'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || data_out1 !== e_d1 || rd_valid1 !== e_v1) begin
            miscompares++;
            $display("FAIL random cyc %0d got %h %b / %h %b want %h %b / %h %b", i,
                     data_out0, rd_valid0, data_out1, rd_valid1, e_d0, e_v0, e_d1, e_v1);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(0, 1, 1, 7, 32'hDEAD_BEEF, 4'hF, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 7);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (rd_valid1 !== 1'b0 || data_out1 !== 32'h0 || ready1 !== 1'b0 ||
          rd_valid0 !== 1'b0 || data_out0 !== 32'h0 || ready0 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flush got %h %b %b / %h %b %b want 0 0 0", data_out0, rd_valid0,
                  ready0, data_out1, rd_valid1, ready1);
      end
      // Second reset partway through the sweep must restart it from zero.
      for (int i = 0; i < 5; i++) step(0, 1, 1, 4'(i), 32'h1234_5678, 4'hF, 1, 7);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < D + 4; i++) begin
         step(0, 1, logic'(i < D), 4'(i % D), 32'h7777_7777, 4'hF, logic'(i >= D - 2), 7);
         vectors++;
         if (data_out0 !== e_d0 || rd_valid0 !== e_v0 || ready0 !== m_ready ||
             data_out1 !== e_d1 || rd_valid1 !== e_v1 || ready1 !== m_ready) begin
            miscompares++;
            $display("FAIL reclear cyc %0d got %h %b %b / %h %b %b want %h %b %b / %h %b", i,
                     data_out0, rd_valid0, ready0, data_out1, rd_valid1, ready1,
                     e_d0, e_v0, m_ready, e_d1, e_v1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte_en();
      test_collision();
      test_back_to_back();
      test_range_gating();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sync_sdp_ram.md
# sync_sdp_ram

Parametrised simple-dual-port synchronous SRAM: one write port and one read port with independent addresses, per-byte write enables and a chip select gating both. It clears itself to zero after reset, has a selectable read-during-write collision mode and an optional output pipeline register. It is the general on-chip storage block for buffers and tables in the design, replacing the earlier fixed 8x8 single-port RAM.

## Interface
- ADR, 8: address width in bits
- DAT, 8: data width in bits; must be a multiple of 8
- DPTH, 256: number of words; must satisfy 1 <= DPTH <= 2**ADR
- RD_MODE, 0: same-address collision behaviour; 0 = read-first (old data), 1 = write-first (new merged data)
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cs  input  1  chip select; gates both ports
- we  input  1  write request
- waddr  input  ADR  write address
- data_in  input  DAT  write data
- be  input  DAT/8  byte enables; bit i controls data_in[8i+7:8i]
- rd  input  1  read request
- raddr  input  ADR  read address
- data_out  output  DAT  read data
- rd_valid  output  1  one-cycle pulse marking data_out as valid for a read
- ready  output  1  high when the clear sweep is done and requests are accepted

## Operation
- FSM states:
  - CLEAR: entered on rst. An internal counter walks 0..DPTH-1, writing all-zero to one word per cycle. ready=0.
  - RUN: entered after the write to DPTH-1 completes. ready=1. Stays in RUN until rst.
- A write is accepted when ready & cs & we. Each byte i with be[i]=1 is updated; bytes with be[i]=0 keep their value.
- A read is accepted when ready & cs & rd. data_out takes mem[raddr] after the read latency.
- Write and read may be accepted in the same cycle, with any address pair.
- Same-address collision (accepted write and read, waddr==raddr):
  - RD_MODE=0: data_out = contents before the write.
  - RD_MODE=1: data_out = post-write word (enabled bytes from data_in, the rest old).
- Out-of-range address (value >= DPTH):
  - Write: dropped, memory unchanged.
  - Read: data_out = 0, rd_valid still pulses.
- Requests while ready=0 are ignored: no memory change, no rd_valid, not queued.
- data_out holds its last value between reads. It changes only on a read completion or on rst.
- rd_valid=1 exactly once per accepted read, aligned with the corresponding data_out.

## Timing
- Reset values: data_out=0, rd_valid=0, ready=0, state=CLEAR, counter=0.
- rst asserted at edge N:
  - Clear writes occur at edges N+1 .. N+DPTH.
  - ready=1 from edge N+DPTH onward.
  - The first accepted request is in the cycle after ready rises.
- rst mid-operation: in-flight reads are flushed (no rd_valid), outputs return to reset values, and the clear sweep restarts from 0.
- rst asserted during CLEAR restarts the sweep at 0.
- Read latency, from the request edge:
  - OUT_REG=0: read accepted at edge T gives data_out and rd_valid at edge T+1.
  - OUT_REG=1: they appear at T+2.
  - Back-to-back reads give one result per cycle in both modes.
- Write visibility: a write at edge T is readable by a read accepted at T+1 (or at T itself if RD_MODE=1).
- cs=0 with we/rd high: no effect; rd_valid=0 the next cycle.

## Test plan
- Reset and clear, DPTH=16: assert rst 1 cycle -> ready low for 16 cycles, then high. Read all addresses -> each 0x00 with rd_valid.
- Byte enables, DAT=32: write 0xAABBCCDD be=4'b1111 to addr 3, then 0x11223344 be=4'b0101 -> read addr 3 returns 0xAA22CC44 one cycle after the request.
- Collision: mem[5]=0x10, write 0x99 to 5 and read 5 in the same cycle -> RD_MODE=0 returns 0x10; RD_MODE=1 returns 0x99.
- Pipelining, OUT_REG=1: reads of addrs 0,1,2 on consecutive cycles -> data_out shows the three words on cycles T+2..T+4, with rd_valid high for exactly 3 cycles.
- Range and gating, DPTH=12, ADR=4:
  - Write 0x55 to addr 13 -> dropped.
  - Read 13 -> 0x00 with rd_valid.
  - Read with cs=0 -> no rd_valid, data_out unchanged.
- Reset mid-flight: issue a read, assert rst the next cycle -> no rd_valid, data_out=0, ready=0. A full clear re-runs, and previously written data reads back 0.
